lreport: RTL and testbench

Beacon report generator and stream merger sitting directly upstream of the beacon update stage. It forwards the 134-bit packet stream unchanged through a small FIFO. Periodically, and after every applied beacon update, it inserts an 8-word beacon report message at a packet boundary. The report echoes the local configuration registers plus forwarding statistics to the controller.

---
 rtl/lreport.sv | 204 ++++++++++++++++++++
 tb/tb_lreport.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lreport.sv
// lreport: beacon report generator and packet stream merger.
//
// The 134-bit packet stream passes through a small FIFO unchanged.
// A report request comes from the periodic timer or from an edge on
// beacon_update_master. When one is pending, an 8-word report message is
// inserted between packets. The report carries the local configuration
// and the forwarding statistics.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_lr_data[133:0]          input word ([133:132] 01 head/11 body/10 tail)
//   in_lr_data_wr              input word strobe
//   in_lr_data_valid(_wr)      packet-valid flag and its strobe (on tail)
//   in_local_mac_id            report source MAC
//   in_ctrl_mac_id             report destination MAC
//   report_period              report interval in cycles, 0 = no periodic reports
//   beacon_update_master       toggles once per applied beacon update
//   time_slot_period, direction, token_bucket_para, direct_mac_addr
//                              configuration echoed in report word 5
//   out_lr_data(_wr)           output word and strobe
//   out_lr_data_valid(_wr)     output packet-valid flag and strobe
//   drop_cnt                   words dropped on FIFO full (saturating)
module lreport #(
  parameter logic [7:0]  LMID            = 8'd11,
  parameter logic [15:0] ETH_TYPE        = 16'h1662,
  parameter logic [3:0]  MSG_TYPE_REPORT = 4'he,
  parameter int          FIFO_AW         = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [133:0] in_lr_data,
  input  logic         in_lr_data_wr,
  input  logic         in_lr_data_valid,
  input  logic         in_lr_data_valid_wr,
  input  logic [47:0]  in_local_mac_id,
  input  logic [47:0]  in_ctrl_mac_id,
  input  logic [31:0]  report_period,
  input  logic         beacon_update_master,
  input  logic [31:0]  time_slot_period,
  input  logic         direction,
  input  logic [31:0]  token_bucket_para,
  input  logic [47:0]  direct_mac_addr,
  output logic [133:0] out_lr_data,
  output logic         out_lr_data_wr,
  output logic         out_lr_data_valid,
  output logic         out_lr_data_valid_wr,
  output logic [31:0]  drop_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, PASS, REPORT} state_t;

  // ---------------- FIFO: {valid_wr, valid, data} ----------------
  logic [135:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               fifo_full, fifo_empty, wr_en, pop;
  logic [135:0]       rd_word;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);
  assign wr_en      = in_lr_data_wr && !fifo_full;
  assign rd_word    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {in_lr_data_valid_wr, in_lr_data_valid, in_lr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      drop_cnt   <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // The full check uses the occupancy before this cycle's pop.
      if (in_lr_data_wr && fifo_full && drop_cnt != 32'hFFFF_FFFF)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

  // ---------------- input framing ----------------
  logic head_wr, tail_wr, in_pkt_reg;
  assign head_wr = in_lr_data_wr && (in_lr_data[133:132] == 2'b01);
  assign tail_wr = in_lr_data_wr && (in_lr_data[133:132] == 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       in_pkt_reg <= 1'b0;
    else if (head_wr) in_pkt_reg <= 1'b1;
    else if (tail_wr) in_pkt_reg <= 1'b0;
  end

  // ---------------- report triggers ----------------
  logic [31:0] timer_reg;
  logic        timer_wrap, bum_q1_reg, bum_q2_reg, bum_edge, pending_reg;
  state_t      state_reg;
  logic        rpt_go;

  assign timer_wrap = (report_period != 32'd0) && (timer_reg >= report_period - 32'd1);
  // Compare the registered copy with its previous value, so an update
  // edge reaches report_pending two cycles after the input changes.
  assign bum_edge   = bum_q1_reg != bum_q2_reg;
  assign rpt_go     = (state_reg == IDLE) && pending_reg && fifo_empty &&
                      !in_pkt_reg && !head_wr;
  // A report only starts with an empty FIFO, so popping does not need rpt_go.
  assign pop        = !fifo_empty && (state_reg != REPORT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg   <= '0;
      bum_q1_reg  <= 1'b0;
      bum_q2_reg  <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      if (report_period == 32'd0 || timer_wrap) timer_reg <= '0;
      else                                      timer_reg <= timer_reg + 32'd1;
      bum_q1_reg <= beacon_update_master;
      bum_q2_reg <= bum_q1_reg;
      // A new trigger wins over the clear, so it is not lost.
      if (timer_wrap || bum_edge) pending_reg <= 1'b1;
      else if (rpt_go)            pending_reg <= 1'b0;
    end
  end

  // ---------------- output FSM ----------------
  logic [2:0]   rpt_cnt_reg;
  logic [31:0]  seq_num_reg, fwd_cnt_reg;
  logic [127:0] w1_reg, w5_reg;
  logic [133:0] rpt_word;

  always_comb begin
    rpt_word = {2'b11, 4'h0, 128'h0};
    case (rpt_cnt_reg)
      3'd1:    rpt_word = {2'b11, 4'h0, w1_reg};
      3'd5:    rpt_word = {2'b11, 4'h0, w5_reg};
      3'd7:    rpt_word = {2'b10, 4'h0, 128'h0};
      default: rpt_word = {2'b11, 4'h0, 128'h0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= IDLE;
      rpt_cnt_reg          <= '0;
      seq_num_reg          <= '0;
      fwd_cnt_reg          <= '0;
      w1_reg               <= '0;
      w5_reg               <= '0;
      out_lr_data          <= '0;
      out_lr_data_wr       <= 1'b0;
      out_lr_data_valid    <= 1'b0;
      out_lr_data_valid_wr <= 1'b0;
    end else begin
      out_lr_data          <= '0;
      out_lr_data_wr       <= 1'b0;
      out_lr_data_valid    <= 1'b0;
      out_lr_data_valid_wr <= 1'b0;
      if (state_reg == REPORT) begin
        out_lr_data    <= rpt_word;
        out_lr_data_wr <= 1'b1;
        if (rpt_cnt_reg == 3'd7) begin
          out_lr_data_valid    <= 1'b1;
          out_lr_data_valid_wr <= 1'b1;
          seq_num_reg          <= seq_num_reg + 32'd1;
          state_reg            <= IDLE;
        end else begin
          rpt_cnt_reg <= rpt_cnt_reg + 3'd1;
        end
      end else if (rpt_go) begin
        // Word 0 goes out now. Words 1 and 5 are snapshotted here so that
        // counters moving during the report do not tear the message.
        out_lr_data    <= {2'b01, 4'h0, in_ctrl_mac_id, in_local_mac_id,
                           ETH_TYPE, 4'h0, MSG_TYPE_REPORT, LMID};
        out_lr_data_wr <= 1'b1;
        w1_reg         <= {seq_num_reg, fwd_cnt_reg, report_period, drop_cnt};
        w5_reg         <= {direct_mac_addr, direction, 15'h0, token_bucket_para,
                           time_slot_period};
        rpt_cnt_reg    <= 3'd1;
        state_reg      <= REPORT;
      end else if (pop) begin
        out_lr_data          <= rd_word[133:0];
        out_lr_data_wr       <= 1'b1;
        out_lr_data_valid    <= rd_word[134];
        out_lr_data_valid_wr <= rd_word[135];
        if (rd_word[133:132] == 2'b10) begin
          fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
          state_reg   <= IDLE;
        end else begin
          state_reg <= PASS;
        end
      end
    end
  end

endmodule

// File: tb/tb_lreport.sv
module tb_lreport;
  logic clk = 1'b0, rst_n = 1'b0, rst_n2 = 1'b0;
  logic [133:0] in_lr_data = '0;
  logic in_lr_data_wr = 1'b0, in_lr_data_valid = 1'b0, in_lr_data_valid_wr = 1'b0;
  logic [47:0] local_mac = 48'h001122334455, ctrl_mac = 48'h66778899aabb;
  logic [47:0] dmac = 48'h0a0b0c0d0e0f;
  logic [31:0] report_period = 32'd0, tsp = 32'h7a12, tbp = 32'd10;
  logic bum = 1'b0, dir = 1'b1;

  logic [133:0] o1_data, o2_data;
  logic o1_wr, o1_v, o1_vwr, o2_wr, o2_v, o2_vwr;
  logic [31:0] drop1, drop2;

  lreport dut (
    .clk(clk), .rst_n(rst_n), .in_lr_data(in_lr_data), .in_lr_data_wr(in_lr_data_wr),
    .in_lr_data_valid(in_lr_data_valid), .in_lr_data_valid_wr(in_lr_data_valid_wr),
    .in_local_mac_id(local_mac), .in_ctrl_mac_id(ctrl_mac), .report_period(report_period),
    .beacon_update_master(bum), .time_slot_period(tsp), .direction(dir),
    .token_bucket_para(tbp), .direct_mac_addr(dmac), .out_lr_data(o1_data),
    .out_lr_data_wr(o1_wr), .out_lr_data_valid(o1_v), .out_lr_data_valid_wr(o1_vwr),
    .drop_cnt(drop1));

  lreport #(.FIFO_AW(2)) dut2 (
    .clk(clk), .rst_n(rst_n2), .in_lr_data(in_lr_data), .in_lr_data_wr(in_lr_data_wr),
    .in_lr_data_valid(in_lr_data_valid), .in_lr_data_valid_wr(in_lr_data_valid_wr),
    .in_local_mac_id(local_mac), .in_ctrl_mac_id(ctrl_mac), .report_period(report_period),
    .beacon_update_master(bum), .time_slot_period(tsp), .direction(dir),
    .token_bucket_para(tbp), .direct_mac_addr(dmac), .out_lr_data(o2_data),
    .out_lr_data_wr(o2_wr), .out_lr_data_valid(o2_v), .out_lr_data_valid_wr(o2_vwr),
    .drop_cnt(drop2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [135:0] q1[$], q2[$];
  int c1[$], c2[$];
  always @(negedge clk) begin
    if (o1_wr) begin q1.push_back({o1_vwr, o1_v, o1_data}); c1.push_back(cyc); end
    if (o2_wr) begin q2.push_back({o2_vwr, o2_v, o2_data}); c2.push_back(cyc); end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [133:0] d, input logic v, input logic vw);
    in_lr_data = d; in_lr_data_wr = 1'b1; in_lr_data_valid = v; in_lr_data_valid_wr = vw;
    tick();
  endtask

  task automatic idle_n(input int n);
    in_lr_data = '0; in_lr_data_wr = 1'b0; in_lr_data_valid = 1'b0; in_lr_data_valid_wr = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [133:0] pw(input logic [1:0] t, input int i);
    return {t, 4'h0, 32'hA5A5_0000 + 32'(i), 32'(i), 32'hDEAD_0000 + 32'(i), 32'(i * 3)};
  endfunction

  // Expected stored/forwarded entry for word i of an n-word packet.
  function automatic logic [135:0] pkw(input int base, input int i, input int n);
    logic [1:0] t;
    t = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    return {(i == n - 1) ? 2'b11 : 2'b00, pw(t, base + i)};
  endfunction

  // Drives an n-word packet; toggles beacon_update_master before word tog_at.
  task automatic send_pkt(input int base, input int n, input int tog_at);
    logic [135:0] e;
    for (int i = 0; i < n; i++) begin
      if (i == tog_at) bum = ~bum;
      e = pkw(base, i, n);
      drive(e[133:0], e[134], e[135]);
    end
    idle_n(0);
  endtask

  task automatic wait_q(input int which, input int n, input int budget);
    int k = 0;
    while (((which == 1) ? q1.size() : q2.size()) < n && k < budget) begin tick(); k++; end
    if (((which == 1) ? q1.size() : q2.size()) < n) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_q%0d: got %0d words required %0d", which, 
               (which == 1) ? q1.size() : q2.size(), n);
    end
  endtask

  task automatic popw(input int which, output logic [135:0] w, output int c);
    w = 'x; c = -1;
    if (which == 1 && q1.size() > 0) begin w = q1.pop_front(); c = c1.pop_front(); end
    if (which == 2 && q2.size() > 0) begin w = q2.pop_front(); c = c2.pop_front(); end
  endtask

  task automatic check_report(input int which, input string tag, input logic [31:0] seq,
                              input logic [31:0] fwd, input logic [31:0] per,
                              input logic [31:0] drp, input int exp_c0);
    logic [135:0] w, e;
    int c;
    for (int i = 0; i < 8; i++) begin
      popw(which, w, c);
      case (i)
        0: e = {2'b00, 2'b01, 4'h0, ctrl_mac, local_mac, 16'h1662, 4'h0, 4'he, 8'd11};
        1: e = {2'b00, 2'b11, 4'h0, seq, fwd, per, drp};
        5: e = {2'b00, 2'b11, 4'h0, dmac, dir, 15'h0, tbp, tsp};
        7: e = {2'b11, 2'b10, 4'h0, 128'h0};
        default: e = {2'b00, 2'b11, 4'h0, 128'h0};
      endcase
      chk($sformatf("%s_w%0d", tag, i), w, e);
      if (i == 0) chk($sformatf("%s_w0_cycle", tag), 136'(c), 136'(exp_c0));
    end
  endtask

  typedef struct {
    logic [133:0] din;
    logic         vld;
    logic         vwr;
    logic [135:0] exp;
  } vec_t;
  vec_t tbl[4];

  initial begin
    logic [135:0] w;
    int c, k, t0;
    int kept[6];
    kept = '{0, 1, 2, 3, 8, 9};

    tbl[0] = '{pw(2'b01, 0), 1'b0, 1'b0, {2'b00, pw(2'b01, 0)}};
    tbl[1] = '{pw(2'b11, 1), 1'b0, 1'b0, {2'b00, pw(2'b11, 1)}};
    tbl[2] = '{pw(2'b11, 2), 1'b0, 1'b0, {2'b00, pw(2'b11, 2)}};
    tbl[3] = '{pw(2'b10, 3), 1'b1, 1'b1, {2'b11, pw(2'b10, 3)}};

    // Reset state
    repeat (3) tick();
    chk("rst_data", 136'(o1_data), 136'h0);
    chk("rst_wr", 136'(o1_wr), 136'h0);
    chk("rst_valid", 136'(o1_v), 136'h0);
    chk("rst_valid_wr", 136'(o1_vwr), 136'h0);
    chk("rst_drop", 136'(drop1), 136'h0);
    rst_n = 1'b1;
    idle_n(3);

    // Pass-through, table driven: two cycles of latency
    t0 = cyc;
    for (int i = 0; i < 4; i++) drive(tbl[i].din, tbl[i].vld, tbl[i].vwr);
    idle_n(1);
    wait_q(1, 4, 20);
    for (int i = 0; i < 4; i++) begin
      popw(1, w, c);
      chk($sformatf("pass_w%0d", i), w, tbl[i].exp);
      chk($sformatf("pass_w%0d_cycle", i), 136'(c), 136'(t0 + i + 2));
    end

    // Update trigger, no periodic reports: w0 three cycles after the toggle
    idle_n(3);
    k = cyc; bum = ~bum;
    wait_q(1, 8, 30);
    check_report(1, "upd", 32'd0, 32'd1, 32'd0, 32'd0, k + 3);

    // Periodic reports every 100 cycles
    idle_n(2);
    k = cyc; report_period = 32'd100;
    wait_q(1, 8, 150);
    check_report(1, "per1", 32'd1, 32'd1, 32'd100, 32'd0, k + 101);
    wait_q(1, 8, 150);
    check_report(1, "per2", 32'd2, 32'd1, 32'd100, 32'd0, k + 201);
    report_period = 32'd0;

    // Deferral: trigger inside a 20-word packet, then a packet arrives
    // during the report and must come out intact after word 7
    idle_n(2);
    k = cyc;
    send_pkt(100, 20, 1);
    idle_n(2);
    send_pkt(200, 4, -1);
    wait_q(1, 32, 60);
    for (int i = 0; i < 20; i++) begin
      popw(1, w, c);
      chk($sformatf("defer_pkt_w%0d", i), w, pkw(100, i, 20));
      if (i == 19) chk("defer_tail_cycle", 136'(c), 136'(k + 21));
    end
    check_report(1, "defer", 32'd3, 32'd2, 32'd0, 32'd0, k + 22);
    for (int i = 0; i < 4; i++) begin
      popw(1, w, c);
      chk($sformatf("after_rpt_w%0d", i), w, pkw(200, i, 4));
      if (i == 0) chk("after_rpt_head_cycle", 136'(c), 136'(k + 30));
    end
    chk("defer_drop", 136'(drop1), 136'h0);

    // Overflow on the 4-deep instance: 10-word burst from report word 0 on.
    // Words 4..7 hit a full FIFO (the pop starts in the cycle of word 7).
    rst_n2 = 1'b1;
    idle_n(3);
    k = cyc; bum = ~bum;
    idle_n(3);
    send_pkt(300, 10, -1);
    idle_n(1);
    wait_q(2, 14, 40);
    check_report(2, "ovf2", 32'd0, 32'd0, 32'd0, 32'd0, k + 3);
    for (int i = 0; i < 6; i++) begin
      popw(2, w, c);
      chk($sformatf("ovf2_kept%0d", i), w, pkw(300, kept[i], 10));
    end
    chk("ovf2_drop", 136'(drop2), 136'd4);
    chk("ovf2_extra_words", 136'(q2.size()), 136'd0);
    wait_q(1, 18, 40);
    check_report(1, "ovf1", 32'd4, 32'd3, 32'd0, 32'd0, k + 3);
    for (int i = 0; i < 10; i++) begin
      popw(1, w, c);
      chk($sformatf("ovf1_pkt_w%0d", i), w, pkw(300, i, 10));
    end
    chk("ovf1_drop", 136'(drop1), 136'h0);

    // Reset in the middle of a report
    idle_n(3);
    bum = ~bum;
    wait_q(1, 1, 20);
    idle_n(2);
    rst_n = 1'b0; rst_n2 = 1'b0;
    #1;
    q1.delete(); c1.delete(); q2.delete(); c2.delete();
    chk("midrst_data", 136'(o1_data), 136'h0);
    chk("midrst_wr", 136'(o1_wr), 136'h0);
    chk("midrst_valid", 136'(o1_v), 136'h0);
    chk("midrst_valid_wr", 136'(o1_vwr), 136'h0);
    chk("midrst_drop2", 136'(drop2), 136'h0);
    idle_n(3);
    rst_n = 1'b1;
    idle_n(20);
    chk("postrst_words", 136'(q1.size()), 136'd0);
    chk("postrst_wr", 136'(o1_wr), 136'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
